// File: rtl/svm_scheduler.sv
// Fall-detection SVM scheduler: collects a frame of feature words, launches the SVM core,
// waits for its verdict with a timeout, and filters verdicts into a confirmed-fall alarm.
module svm_scheduler #(
  parameter int unsigned N_FEAT      = 7,
  parameter int unsigned CONFIRM_CNT = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        feat_valid,
  input  logic [15:0] feat_data,
  input  logic        feat_last,
  output logic        feat_ready,
  output logic        svm_start,
  output logic [15:0] svm_feature_0,
  output logic [15:0] svm_feature_1,
  output logic [15:0] svm_feature_2,
  output logic [15:0] svm_feature_3,
  output logic [15:0] svm_feature_4,
  output logic [15:0] svm_feature_5,
  output logic [15:0] svm_feature_6,
  input  logic        svm_done,
  input  logic        svm_fall,
  output logic        result_valid,
  output logic        result_fall,
  output logic        alarm,
  input  logic        alarm_clear,
  output logic        frame_error,
  output logic        timeout,
  output logic [15:0] frame_count
);

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned CNF_W = (CONFIRM_CNT > 0) ? $clog2(CONFIRM_CNT + 1) : 1;
  localparam int unsigned N_OUT = 7;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNF_W-1:0] CNF_MAX  = CNF_W'(CONFIRM_CNT);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNF_W-1:0] conf_q;
  logic [CNF_W-1:0] conf_d_c;
  logic [15:0]      slot_q [N_FEAT];
  logic [15:0]      feat_out_c [N_OUT];

  logic accept_c;
  logic at_last_c;
  logic frame_ok_c;
  logic frame_bad_c;
  logic done_hit_c;
  logic tmo_hit_c;
  logic alarm_set_c;

  // Frame framing: a frame is good only if last coincides with the final slot
  assign accept_c    = feat_valid & feat_ready & (state_q == ST_COLLECT);
  assign at_last_c   = (idx_q == IDX_LAST);
  assign frame_ok_c  = accept_c & at_last_c & feat_last;
  assign frame_bad_c = accept_c & (at_last_c ^ feat_last);

  // Completion wins over timeout on the final wait cycle
  assign done_hit_c = (state_q == ST_WAIT) & svm_done;
  assign tmo_hit_c  = (state_q == ST_WAIT) & ~svm_done & (timer_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    conf_d_c    = conf_q;
    alarm_set_c = 1'b0;
    case (state_q)
      ST_COLLECT: if (frame_ok_c) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_hit_c) begin
          state_d = ST_REPORT;
        end else if (tmo_hit_c) begin
          state_d = ST_COLLECT;
        end
      end
      ST_REPORT: begin
        state_d = ST_COLLECT;
        if (result_fall) begin
          conf_d_c    = (conf_q == CNF_MAX) ? conf_q : conf_q + CNF_W'(1);
          alarm_set_c = (conf_d_c == CNF_MAX);
        end else begin
          conf_d_c = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Handshake and status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      feat_ready   <= 1'b0;
      svm_start    <= 1'b0;
      result_valid <= 1'b0;
      result_fall  <= 1'b0;
      frame_error  <= 1'b0;
      timeout      <= 1'b0;
      alarm        <= 1'b0;
      frame_count  <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      conf_q       <= '0;
    end else begin
      feat_ready   <= (state_d == ST_COLLECT);
      svm_start    <= (state_d == ST_LAUNCH);
      result_valid <= done_hit_c;
      frame_error  <= frame_bad_c;
      timeout      <= tmo_hit_c;

      if (accept_c) begin
        idx_q <= (frame_ok_c || frame_bad_c) ? '0 : idx_q + IDX_W'(1);
      end

      if (state_q == ST_LAUNCH) begin
        timer_q <= '0;
      end else if (state_q == ST_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      if (done_hit_c) begin
        result_fall <= svm_fall;
      end

      if (state_q == ST_REPORT) begin
        conf_q      <= conf_d_c;
        frame_count <= frame_count + 16'd1;
      end else if (tmo_hit_c) begin
        conf_q <= '0;
      end

      if (alarm_set_c) begin
        alarm <= 1'b1;
      end else if (alarm_clear) begin
        alarm <= 1'b0;
      end
    end
  end

  // Slots only change while collecting, so they hold steady for the whole SVM run
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        slot_q[k] <= '0;
      end
    end else if (accept_c) begin
      slot_q[idx_q] <= feat_data;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_feat_out
    if (g < N_FEAT) begin : g_used
      assign feat_out_c[g] = slot_q[g];
    end else begin : g_unused
      assign feat_out_c[g] = '0;
    end
  end

  assign svm_feature_0 = feat_out_c[0];
  assign svm_feature_1 = feat_out_c[1];
  assign svm_feature_2 = feat_out_c[2];
  assign svm_feature_3 = feat_out_c[3];
  assign svm_feature_4 = feat_out_c[4];
  assign svm_feature_5 = feat_out_c[5];
  assign svm_feature_6 = feat_out_c[6];

endmodule

// File: tb/tb_svm_scheduler.sv
// Directed bench for svm_scheduler: framing, launch/report latency, alarm filtering,
// timeout, reset in WAIT and back-to-back frames.
module tb_svm_scheduler;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        feat_valid;
  logic [15:0] feat_data;
  logic        feat_last;
  logic        feat_ready;
  logic        svm_start;
  logic [15:0] svm_feature_0, svm_feature_1, svm_feature_2, svm_feature_3;
  logic [15:0] svm_feature_4, svm_feature_5, svm_feature_6;
  logic        svm_done;
  logic        svm_fall;
  logic        result_valid;
  logic        result_fall;
  logic        alarm;
  logic        alarm_clear;
  logic        frame_error;
  logic        timeout;
  logic [15:0] frame_count;

  logic [15:0] feat_o [7];
  logic [15:0] cur [7];
  logic [15:0] bb [14];
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  logic        exp_alarm = 1'b0;

  svm_scheduler #(
    .N_FEAT      (7),
    .CONFIRM_CNT (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .feat_valid    (feat_valid),
    .feat_data     (feat_data),
    .feat_last     (feat_last),
    .feat_ready    (feat_ready),
    .svm_start     (svm_start),
    .svm_feature_0 (svm_feature_0),
    .svm_feature_1 (svm_feature_1),
    .svm_feature_2 (svm_feature_2),
    .svm_feature_3 (svm_feature_3),
    .svm_feature_4 (svm_feature_4),
    .svm_feature_5 (svm_feature_5),
    .svm_feature_6 (svm_feature_6),
    .svm_done      (svm_done),
    .svm_fall      (svm_fall),
    .result_valid  (result_valid),
    .result_fall   (result_fall),
    .alarm         (alarm),
    .alarm_clear   (alarm_clear),
    .frame_error   (frame_error),
    .timeout       (timeout),
    .frame_count   (frame_count)
  );

  assign feat_o[0] = svm_feature_0;
  assign feat_o[1] = svm_feature_1;
  assign feat_o[2] = svm_feature_2;
  assign feat_o[3] = svm_feature_3;
  assign feat_o[4] = svm_feature_4;
  assign feat_o[5] = svm_feature_5;
  assign feat_o[6] = svm_feature_6;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [15:0] base);
    for (int k = 0; k < 7; k++) cur[k] = base + 16'(k);
  endtask

  // Present n words of cur[]; feat_last on word index last_at (-1 for none)
  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      chk1("word_ready", feat_ready, 1'b1);
      feat_valid = 1'b1;
      feat_data  = cur[i];
      feat_last  = (i == last_at);
      tick;
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    feat_data  = 16'h0;
  endtask

  // Called in the LAUNCH cycle; SVM answers dly cycles after svm_start; returns in REPORT
  task automatic run_svm(input int dly, input logic fall);
    for (int i = 0; i < dly; i++) tick;
    svm_done = 1'b1;
    svm_fall = fall;
    tick;
    svm_done = 1'b0;
    svm_fall = 1'b0;
  endtask

  task automatic classify(input logic fall, input logic alarm_after, input logic clr, input int dly);
    send_frame(7, 6);
    chk1("launch_start", svm_start, 1'b1);
    chk1("launch_ready", feat_ready, 1'b0);
    for (int k = 0; k < 7; k++) chk16("launch_feat", feat_o[k], cur[k]);
    run_svm(dly, fall);
    chk1("report_valid", result_valid, 1'b1);
    chk1("report_fall", result_fall, fall);
    chk1("report_tmo", timeout, 1'b0);
    chk1("report_alarm", alarm, exp_alarm);
    alarm_clear = clr;
    tick;
    alarm_clear = 1'b0;
    exp_count++;
    exp_alarm = alarm_after;
    chk1("post_valid", result_valid, 1'b0);
    chk16("post_count", frame_count, 16'(exp_count));
    chk1("post_ready", feat_ready, 1'b1);
    chk1("post_alarm", alarm, exp_alarm);
  endtask

  task automatic clear_alarm;
    alarm_clear = 1'b1;
    tick;
    alarm_clear = 1'b0;
    exp_alarm = 1'b0;
    chk1("alarm_cleared", alarm, 1'b0);
  endtask

  initial begin
    int   p, starts, reports, wcnt;
    logic busy, rdy, dn;

    reset = 1'b1; feat_valid = 1'b0; feat_data = 16'h0; feat_last = 1'b0;
    svm_done = 1'b0; svm_fall = 1'b0; alarm_clear = 1'b0;
    tick;
    tick;
    chk1("rst_ready", feat_ready, 1'b0);
    chk1("rst_start", svm_start, 1'b0);
    chk1("rst_valid", result_valid, 1'b0);
    chk1("rst_alarm", alarm, 1'b0);
    chk1("rst_ferr", frame_error, 1'b0);
    chk1("rst_tmo", timeout, 1'b0);
    chk16("rst_count", frame_count, 16'h0);
    chk16("rst_feat0", feat_o[0], 16'h0);
    chk16("rst_feat6", feat_o[6], 16'h0);
    reset = 1'b0;
    tick;
    chk1("rst_release_ready", feat_ready, 1'b1);

    // Reference frame, fall verdict after 5 cycles
    cur[0] = 16'h0010; cur[1] = 16'hFFF0; cur[2] = 16'h0100; cur[3] = 16'h0001;
    cur[4] = 16'h7FFF; cur[5] = 16'h8000; cur[6] = 16'h0002;
    classify(1'b1, 1'b0, 1'b0, 5);
    chk16("ref_feat5", svm_feature_5, 16'h8000);

    // Second consecutive fall confirms the alarm
    set_cur(16'h1000);
    classify(1'b1, 1'b1, 1'b0, 5);
    clear_alarm;

    // Non-consecutive falls never confirm
    set_cur(16'h1100); classify(1'b0, 1'b0, 1'b0, 3);
    set_cur(16'h1200); classify(1'b1, 1'b0, 1'b0, 4);
    set_cur(16'h1300); classify(1'b0, 1'b0, 1'b0, 2);
    set_cur(16'h1400); classify(1'b1, 1'b0, 1'b0, 6);

    // Clear during the set event: set wins
    set_cur(16'h1500); classify(1'b1, 1'b1, 1'b1, 5);
    clear_alarm;

    // Early last: error, partial slots kept, no launch
    set_cur(16'h3000);
    send_frame(4, 3);
    chk1("early_ferr", frame_error, 1'b1);
    chk1("early_start", svm_start, 1'b0);
    chk1("early_ready", feat_ready, 1'b1);
    chk16("early_slot0", feat_o[0], 16'h3000);
    tick;
    chk1("early_ferr_pulse", frame_error, 1'b0);

    // Missing last on word 7: error, no launch
    set_cur(16'h3100);
    send_frame(7, -1);
    chk1("nolast_ferr", frame_error, 1'b1);
    chk1("nolast_start", svm_start, 1'b0);
    tick;
    chk1("nolast_idle_start", svm_start, 1'b0);

    set_cur(16'h4000); classify(1'b0, 1'b0, 1'b0, 5);
    set_cur(16'h4100); classify(1'b1, 1'b0, 1'b0, 5);

    // Timeout: pulse TMO cycles after WAIT entry, confirm counter cleared
    set_cur(16'h5000);
    send_frame(7, 6);
    chk1("tmo_start", svm_start, 1'b1);
    tick;
    for (int i = 1; i < TMO; i++) tick;
    chk1("tmo_early", timeout, 1'b0);
    tick;
    chk1("tmo_pulse", timeout, 1'b1);
    chk1("tmo_valid", result_valid, 1'b0);
    chk1("tmo_ready", feat_ready, 1'b1);
    chk16("tmo_count", frame_count, 16'(exp_count));
    tick;
    chk1("tmo_pulse_end", timeout, 1'b0);
    set_cur(16'h5100); classify(1'b1, 1'b0, 1'b0, 5);

    // svm_done on the last wait cycle beats timeout
    set_cur(16'h5200); classify(1'b1, 1'b1, 1'b0, TMO);
    clear_alarm;

    // svm_done while idle is ignored
    svm_done = 1'b1; svm_fall = 1'b1;
    tick;
    svm_done = 1'b0; svm_fall = 1'b0;
    chk1("idle_done_valid0", result_valid, 1'b0);
    tick;
    chk1("idle_done_valid1", result_valid, 1'b0);
    chk16("idle_done_count", frame_count, 16'(exp_count));

    // Back-to-back frames with feat_valid held high
    for (int i = 0; i < 14; i++) bb[i] = 16'h2100 + 16'(i);
    p = 0; starts = 0; reports = 0; wcnt = -1; busy = 1'b0;
    for (int c = 0; c < 120 && reports < 2; c++) begin
      feat_valid = (p < 14);
      feat_data  = (p < 14) ? bb[p] : 16'h0;
      feat_last  = (p % 7 == 6);
      svm_done   = (wcnt == 3);
      svm_fall   = 1'b0;
      rdy = feat_ready;
      dn  = svm_done;
      tick;
      if (rdy && p < 14) p++;
      if (dn) wcnt = -1;
      else if (wcnt >= 0) wcnt++;
      if (svm_start) begin
        for (int k = 0; k < 7; k++) chk16("bb_feat", feat_o[k], bb[starts * 7 + k]);
        starts++;
        wcnt = 0;
        busy = 1'b1;
      end
      if (busy) chk1("bb_ready_low", feat_ready, 1'b0);
      if (result_valid) begin
        reports++;
        busy = 1'b0;
      end
    end
    feat_valid = 1'b0; feat_last = 1'b0; svm_done = 1'b0;
    chk16("bb_words", 16'(p), 16'd14);
    chk16("bb_starts", 16'(starts), 16'd2);
    chk16("bb_reports", 16'(reports), 16'd2);
    tick;
    exp_count += 2;
    chk16("bb_count", frame_count, 16'(exp_count));

    // Reset while waiting, then a late svm_done
    set_cur(16'h6000);
    send_frame(7, 6);
    chk1("rw_start", svm_start, 1'b1);
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk1("rw_rst_ready", feat_ready, 1'b0);
    chk16("rw_rst_count", frame_count, 16'h0);
    reset = 1'b0;
    svm_done = 1'b1; svm_fall = 1'b1;
    tick;
    svm_done = 1'b0; svm_fall = 1'b0;
    chk1("rw_ready", feat_ready, 1'b1);
    chk1("rw_valid0", result_valid, 1'b0);
    tick;
    chk1("rw_valid1", result_valid, 1'b0);
    chk16("rw_count", frame_count, 16'h0);
    chk16("rw_feat0", feat_o[0], 16'h0);
    chk1("rw_alarm", alarm, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
